// File: rtl/onewire_pkg.sv
// Shared op codes, FSM/slot encodings and default bit-slot timing for the 1-Wire sequencer.
package onewire_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam int DEF_T_LOW1   = 6;
  localparam int DEF_T_SLOT   = 60;
  localparam int DEF_T_REC    = 11;
  localparam int DEF_T_RDSAMP = 13;
  localparam int DEF_T_RST    = 480;
  localparam int DEF_T_PDSAMP = 70;
  localparam int DEF_T_RSTREC = 410;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_REL,
    ST_SLOT_LOW,
    ST_SLOT_REL,
    ST_SLOT_REC
  } state_t;

  typedef enum logic [1:0] {
    BT_W0,
    BT_W1,
    BT_RD
  } bit_type_t;

  // Slot flavour for the current bit: reads always use the short low pulse.
  function automatic bit_type_t slot_type(input logic [1:0] code, input logic wbit);
    if (code == OP_READ) return BT_RD;
    return wbit ? BT_W1 : BT_W0;
  endfunction

endpackage

// File: rtl/onewire_txn_sequencer_if.sv
// Host-side op/response handshake of the 1-Wire sequencer.
interface onewire_txn_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op_code;
  logic [7:0] op_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_presence;

  modport master (
    output op_valid, op_code, op_wdata,
    input  op_ready, rsp_valid, rsp_rdata, rsp_presence
  );

  modport slave (
    input  op_valid, op_code, op_wdata,
    output op_ready, rsp_valid, rsp_rdata, rsp_presence
  );
endinterface

// File: rtl/onewire_slot_timer.sv
// Free-running phase counter with the compare strobes that shape one bit slot.
// The counter runs across low, release and recovery of a slot; the top clears it
// at phase boundaries and also reuses cnt_o for the reset pulse timing.
module onewire_slot_timer
  import onewire_pkg::*;
#(
  parameter int T_LOW1   = DEF_T_LOW1,
  parameter int T_SLOT   = DEF_T_SLOT,
  parameter int T_REC    = DEF_T_REC,
  parameter int T_RDSAMP = DEF_T_RDSAMP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  bit_type_t  bit_type_i,
  output logic [8:0] cnt_o,
  output logic       low_end_o,
  output logic       rel_end_o,
  output logic       rec_end_o,
  output logic       samp_o
);

  localparam logic [8:0] LOW1_M1 = 9'(T_LOW1 - 1);
  localparam logic [8:0] SLOT_M1 = 9'(T_SLOT - 1);
  localparam logic [8:0] REC_M1  = 9'(T_SLOT + T_REC - 1);
  localparam logic [8:0] SAMP    = 9'(T_RDSAMP);

  logic [8:0] cnt_q, cnt_d;

  // Next count: restart from zero on clear, otherwise advance one per cycle.
  always_comb begin
    cnt_d = clr_i ? 9'd0 : cnt_q + 9'd1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 9'd0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign low_end_o = (cnt_q == ((bit_type_i == BT_W0) ? SLOT_M1 : LOW1_M1));
  assign rel_end_o = (cnt_q == SLOT_M1);
  assign rec_end_o = (cnt_q == REC_M1);
  assign samp_o    = (cnt_q == SAMP);

endmodule

// File: rtl/onewire_txn_sequencer.sv
// Byte-level 1-Wire master: sequences reset/presence and 8 LSB-first bit slots per op.
module onewire_txn_sequencer
  import onewire_pkg::*;
#(
  parameter int T_LOW1   = DEF_T_LOW1,
  parameter int T_SLOT   = DEF_T_SLOT,
  parameter int T_REC    = DEF_T_REC,
  parameter int T_RDSAMP = DEF_T_RDSAMP,
  parameter int T_RST    = DEF_T_RST,
  parameter int T_PDSAMP = DEF_T_PDSAMP,
  parameter int T_RSTREC = DEF_T_RSTREC
) (
  input  logic                     clk,
  input  logic                     rst,
  onewire_txn_sequencer_if.slave   host,
  output logic                     master_pull_low,
  input  logic                     bus
);

  localparam logic [8:0] RST_M1    = 9'(T_RST - 1);
  localparam logic [8:0] PDSAMP    = 9'(T_PDSAMP);
  localparam logic [8:0] RSTREC_M1 = 9'(T_RSTREC - 1);

  state_t     state_q;
  logic       pull_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_presence_q;
  logic [1:0] code_q;
  logic [7:0] wdata_q;
  logic [2:0] bit_idx_q;
  logic [7:0] rd_shift_q;
  logic       pres_q;
  logic       bus_meta_q, bus_sync_q;

  logic       cnt_clr;
  logic [8:0] cnt;
  logic       low_end, rel_end, rec_end, samp;
  bit_type_t  bit_type;

  assign bit_type = slot_type(code_q, wdata_q[bit_idx_q]);

  onewire_slot_timer #(
    .T_LOW1   (T_LOW1),
    .T_SLOT   (T_SLOT),
    .T_REC    (T_REC),
    .T_RDSAMP (T_RDSAMP)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .bit_type_i (bit_type),
    .cnt_o      (cnt),
    .low_end_o  (low_end),
    .rel_end_o  (rel_end),
    .rec_end_o  (rec_end),
    .samp_o     (samp)
  );

  // Counter restarts while idle, at the end of the reset pulse and at every slot end.
  always_comb begin
    cnt_clr = (state_q == ST_IDLE)
           || ((state_q == ST_RST_LOW) && (cnt == RST_M1))
           || ((state_q == ST_SLOT_REC) && rec_end);
  end

  // Two-flop synchroniser for the asynchronous line level; idles high like the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_meta_q <= 1'b1;
      bus_sync_q <= 1'b1;
    end else begin
      bus_meta_q <= bus;
      bus_sync_q <= bus_meta_q;
    end
  end

  // Transaction FSM with registered line drive and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pull_q         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 8'h00;
      rsp_presence_q <= 1'b0;
      code_q         <= OP_RESET;
      wdata_q        <= 8'h00;
      bit_idx_q      <= 3'd0;
      rd_shift_q     <= 8'h00;
      pres_q         <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (samp && (code_q == OP_READ) &&
          ((state_q == ST_SLOT_LOW) || (state_q == ST_SLOT_REL))) begin
        rd_shift_q[bit_idx_q] <= bus_sync_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (host.op_valid) begin
            code_q    <= host.op_code;
            wdata_q   <= host.op_wdata;
            bit_idx_q <= 3'd0;
            case (host.op_code)
              OP_RESET: begin
                state_q <= ST_RST_LOW;
                pull_q  <= 1'b1;
              end
              OP_WRITE, OP_READ: begin
                state_q <= ST_SLOT_LOW;
                pull_q  <= 1'b1;
              end
              default: rsp_valid_q <= 1'b1;
            endcase
          end
        end
        ST_RST_LOW: begin
          if (cnt == RST_M1) begin
            state_q <= ST_RST_REL;
            pull_q  <= 1'b0;
          end
        end
        ST_RST_REL: begin
          if (cnt == PDSAMP) pres_q <= ~bus_sync_q;
          if (cnt == RSTREC_M1) begin
            state_q        <= ST_IDLE;
            rsp_valid_q    <= 1'b1;
            rsp_presence_q <= (cnt == PDSAMP) ? ~bus_sync_q : pres_q;
          end
        end
        ST_SLOT_LOW: begin
          if (low_end) begin
            pull_q  <= 1'b0;
            state_q <= (bit_type == BT_W0) ? ST_SLOT_REC : ST_SLOT_REL;
          end
        end
        ST_SLOT_REL: begin
          if (rel_end) state_q <= ST_SLOT_REC;
        end
        ST_SLOT_REC: begin
          if (rec_end) begin
            if (bit_idx_q != 3'd7) begin
              bit_idx_q <= bit_idx_q + 3'd1;
              state_q   <= ST_SLOT_LOW;
              pull_q    <= 1'b1;
            end else begin
              state_q     <= ST_IDLE;
              rsp_valid_q <= 1'b1;
              if (code_q == OP_READ) rsp_rdata_q <= rd_shift_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pull_q  <= 1'b0;
        end
      endcase
    end
  end

  assign host.op_ready     = (state_q == ST_IDLE);
  assign host.rsp_valid    = rsp_valid_q;
  assign host.rsp_rdata    = rsp_rdata_q;
  assign host.rsp_presence = rsp_presence_q;
  assign master_pull_low   = pull_q;

endmodule
